// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: byte width, source limit and
// the arbiter state encoding.
package uart_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned MAX_SRC = 8;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_XFER
  } tx_state_e;

  // Increment with wrap at n, valid for any n (not just powers of two).
  function automatic int unsigned wrap_inc(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo N. Returns one-hot, index and a found flag.
module rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    onehot,
  output logic [IdxW-1:0] idx,
  output logic            found
);

  int unsigned     cand;
  logic [IdxW-1:0] cand_idx;

  always_comb begin
    found    = 1'b0;
    idx      = '0;
    onehot   = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand     = (32'(ptr) + i) % N;
      cand_idx = IdxW'(cand);
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
    if (found) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the tx FIFO write port between byte-stream
// sources; grants are held for a whole frame and writes are paced 1-in-2.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_FRAME = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        src_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] src_data,
  input  logic [NUM_REQ-1:0]        src_last,
  output logic [NUM_REQ-1:0]        src_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      fifo_write_req,
  output logic [BYTE_W-1:0]         fifo_write_data,
  input  logic                      full,
  output logic                      busy,
  output logic                      trunc
);

  localparam int unsigned IdxW   = $clog2(NUM_REQ);
  localparam logic [7:0]  MaxCnt = 8'(MAX_FRAME);

  tx_state_e           state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IdxW-1:0]     gidx_q, gidx_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic [7:0]          count_q, count_d;
  logic                wr_gap_q, wr_gap_d;
  logic                wreq_q, wreq_d;
  logic [BYTE_W-1:0]   wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic                trunc_q, trunc_d;

  logic [NUM_REQ-1:0]  pick_onehot;
  logic [IdxW-1:0]     pick_idx;
  logic                pick_found;
  logic [BYTE_W-1:0]   cur_byte;
  logic                cur_last;
  logic                accept;
  logic [7:0]          count_inc;
  logic                at_max;

  rr_pick #(
    .N    (NUM_REQ),
    .IdxW (IdxW)
  ) u_rr_pick (
    .req    (src_valid),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  // The cycle after an accept is always a gap, leaving room for full to catch up.
  assign src_ready = (state_q == ST_XFER && !full && !wr_gap_q) ? grant_q : '0;
  assign accept    = |(src_valid & src_ready);
  assign cur_last  = |(src_last & grant_q);
  assign count_inc = count_q + 8'd1;
  assign at_max    = (count_inc == MaxCnt);

  always_comb begin
    cur_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        cur_byte = src_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    ptr_d    = ptr_q;
    count_d  = count_q;
    wr_gap_d = 1'b0;
    wreq_d   = 1'b0;
    wdata_d  = wdata_q;
    busy_d   = busy_q;
    trunc_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = pick_onehot;
          gidx_d  = pick_idx;
          count_d = 8'd0;
          busy_d  = 1'b1;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (accept) begin
          wreq_d   = 1'b1;
          wdata_d  = cur_byte;
          wr_gap_d = 1'b1;
          count_d  = count_inc;
          if (cur_last || at_max) begin
            grant_d = '0;
            busy_d  = 1'b0;
            ptr_d   = IdxW'(wrap_inc(32'(gidx_q), NUM_REQ));
            trunc_d = !cur_last;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      ptr_q    <= '0;
      count_q  <= 8'd0;
      wr_gap_q <= 1'b0;
      wreq_q   <= 1'b0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      trunc_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      ptr_q    <= ptr_d;
      count_q  <= count_d;
      wr_gap_q <= wr_gap_d;
      wreq_q   <= wreq_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      trunc_q  <= trunc_d;
    end
  end

  assign grant           = grant_q;
  assign fifo_write_req  = wreq_q;
  assign fifo_write_data = wdata_q;
  assign busy            = busy_q;
  assign trunc           = trunc_q;

endmodule
